// File: rtl/id_fwd_branch_unit.sv
// -----------------------------------------------------------------------------
// id_fwd_branch_unit
//
// Instruction-decode front end for a 5-stage MIPS pipeline.
// - Holds the IF->ID pipeline register (valid, pc). The instruction word comes
//   straight from the synchronous instruction SRAM, so a hold buffer captures
//   it on the first held cycle. Later SRAM reads cannot then overwrite it.
// - Resolves rs/rt through NUM_FWD prioritised forwarding sources, where
//   index 0 is the youngest. It raises stallreq when the winning source for a
//   used operand is not ready yet (load-use).
// - Resolves every MIPS branch/jump in ID and tracks delay-slot status.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   stall_id, stall_ex  stall bits for ID / EX (see pipeline register below)
//   if_ce, if_pc        IF slot valid and pc, loaded into ID
//   inst_sram_rdata     instruction word, one cycle after if_pc
//   rf_raddr1/2         rs / rt read addresses to the external regfile
//   rf_rdata1/2         regfile read data
//   fwd_we/ready/waddr/wdata  forwarding sources (source i at slice i)
//   id_valid, id_pc, id_inst  current ID instruction
//   src1_data/src2_data forwarded rs / rt operands
//   stallreq            load-use hazard
//   br_taken, br_target fetch redirect
//   link_addr           id_pc + 8
//   in_delay_slot       ID instruction sits in a branch/jump delay slot
// -----------------------------------------------------------------------------
module id_fwd_branch_unit #(
  parameter int NUM_FWD = 2,
  parameter int DS_EN   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_id,
  input  logic                   stall_ex,
  input  logic                   if_ce,
  input  logic [31:0]            if_pc,
  input  logic [31:0]            inst_sram_rdata,
  output logic [4:0]             rf_raddr1,
  output logic [4:0]             rf_raddr2,
  input  logic [31:0]            rf_rdata1,
  input  logic [31:0]            rf_rdata2,
  input  logic [NUM_FWD-1:0]     fwd_we,
  input  logic [NUM_FWD-1:0]     fwd_ready,
  input  logic [5*NUM_FWD-1:0]   fwd_waddr,
  input  logic [32*NUM_FWD-1:0]  fwd_wdata,
  output logic                   id_valid,
  output logic [31:0]            id_pc,
  output logic [31:0]            id_inst,
  output logic [31:0]            src1_data,
  output logic [31:0]            src2_data,
  output logic                   stallreq,
  output logic                   br_taken,
  output logic [31:0]            br_target,
  output logic [31:0]            link_addr,
  output logic                   in_delay_slot
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] FN_SLL     = 6'b000000;
  localparam logic [5:0] FN_SRL     = 6'b000010;
  localparam logic [5:0] FN_SRA     = 6'b000011;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic        ds_q, ds_d;

  logic        is_bj;

  // ---- IF -> ID pipeline register and hold buffer ----
  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    hold_valid_d = hold_valid_q;
    hold_inst_d  = hold_inst_q;
    ds_d         = ds_q;
    if (!stall_id) begin
      valid_d      = if_ce;
      pc_d         = if_pc;
      hold_valid_d = 1'b0;
      // Set for any branch/jump leaving ID, taken or not.
      ds_d         = valid_q & is_bj;
    end else if (!stall_ex) begin
      // Bubble: ID is emptied, and delay-slot state survives for the next real instruction.
      valid_d      = 1'b0;
      pc_d         = '0;
      hold_valid_d = 1'b0;
    end else if (!hold_valid_q) begin
      // First held cycle: the SRAM word is still the ID instruction, keep it.
      hold_inst_d  = inst_sram_rdata;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      hold_valid_q <= 1'b0;
      hold_inst_q  <= '0;
      ds_q         <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      hold_valid_q <= hold_valid_d;
      hold_inst_q  <= hold_inst_d;
      ds_q         <= ds_d;
    end
  end

  // ---- ID: decode ----
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt;
  logic [15:0] imm;
  logic        uses_rs, uses_rt;

  assign id_inst = !valid_q      ? 32'd0 :
                   hold_valid_q  ? hold_inst_q : inst_sram_rdata;

  assign op    = id_inst[31:26];
  assign rs    = id_inst[25:21];
  assign rt    = id_inst[20:16];
  assign imm   = id_inst[15:0];
  assign funct = id_inst[5:0];

  assign uses_rs = !((op == OP_LUI) || (op == OP_J) || (op == OP_JAL) ||
                     ((op == OP_SPECIAL) &&
                      ((funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA))));
  assign uses_rt = (op == OP_SPECIAL) || (op == OP_BEQ) || (op == OP_BNE) ||
                   (op[5:3] == 3'b101);

  assign rf_raddr1 = rs;
  assign rf_raddr2 = rt;

  // ---- ID: operand forwarding ----
  // Scan from oldest to youngest so the lowest matching index wins.
  logic rdy1, rdy2;

  always_comb begin
    src1_data = rf_rdata1;
    src2_data = rf_rdata2;
    rdy1      = 1'b1;
    rdy2      = 1'b1;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_we[i] && (fwd_waddr[5*i +: 5] == rs)) begin
        src1_data = fwd_wdata[32*i +: 32];
        rdy1      = fwd_ready[i];
      end
      if (fwd_we[i] && (fwd_waddr[5*i +: 5] == rt)) begin
        src2_data = fwd_wdata[32*i +: 32];
        rdy2      = fwd_ready[i];
      end
    end
    if (rs == 5'd0) begin
      src1_data = '0;
      rdy1      = 1'b1;
    end
    if (rt == 5'd0) begin
      src2_data = '0;
      rdy2      = 1'b1;
    end
  end

  assign stallreq = valid_q & ((uses_rs & ~rdy1) | (uses_rt & ~rdy2));

  // ---- ID: branch / jump resolution ----
  logic signed [31:0] src1_s;
  logic        ltz, gtz;
  logic        is_br, is_jimm, is_jreg, cond;
  logic [31:0] pc_plus4, br_off, tgt;

  assign src1_s = src1_data;
  assign ltz    = (src1_s < 32'sd0);
  assign gtz    = (src1_s > 32'sd0);

  always_comb begin
    is_br   = 1'b0;
    is_jimm = 1'b0;
    is_jreg = 1'b0;
    cond    = 1'b0;
    unique case (op)
      OP_BEQ:  begin is_br = 1'b1; cond = (src1_data == src2_data); end
      OP_BNE:  begin is_br = 1'b1; cond = (src1_data != src2_data); end
      OP_BLEZ: begin is_br = 1'b1; cond = ~gtz; end
      OP_BGTZ: begin is_br = 1'b1; cond = gtz; end
      OP_REGIMM: begin
        // rt[0] selects bgez-type, rt[4] only adds the link.
        if ((rt[3:1] == 3'b000) && !(rt[4] && 1'b0)) begin
          is_br = 1'b1;
          cond  = rt[0] ? ~ltz : ltz;
        end
      end
      OP_J, OP_JAL: begin is_jimm = 1'b1; cond = 1'b1; end
      OP_SPECIAL: begin
        if ((funct == FN_JR) || (funct == FN_JALR)) begin
          is_jreg = 1'b1;
          cond    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign is_bj    = is_br | is_jimm | is_jreg;
  assign pc_plus4 = pc_q + 32'd4;
  assign br_off   = {{14{imm[15]}}, imm, 2'b00};

  always_comb begin
    tgt = pc_plus4 + br_off;
    if (is_jimm)      tgt = {pc_plus4[31:28], id_inst[25:0], 2'b00};
    else if (is_jreg) tgt = src1_data;
  end

  assign br_taken      = valid_q & cond & ~stallreq;
  assign br_target     = br_taken ? tgt : 32'd0;
  assign link_addr     = valid_q ? (pc_q + 32'd8) : 32'd0;
  assign in_delay_slot = (DS_EN != 0) & ds_q & valid_q;
  assign id_valid      = valid_q;
  assign id_pc         = pc_q;

endmodule
